// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared port indices, arbiter state type and XY route function
package router_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] PORT_L = 3'd0;
    localparam logic [2:0] PORT_E = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_N = 3'd3;
    localparam logic [2:0] PORT_S = 3'd4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // X is resolved before Y so packets never turn from a Y hop back to X.
    function automatic logic [2:0] route_port(
        input logic [31:0] dst,
        input int          addr_w,
        input int          x_w,
        input int          local_x,
        input int          local_y
    );
        logic [31:0] dx;
        logic [31:0] dy;
        logic [31:0] lx;
        logic [31:0] ly;
        dx = dst & ((32'd1 << x_w) - 32'd1);
        dy = (dst >> x_w) & ((32'd1 << (addr_w - x_w)) - 32'd1);
        lx = local_x;
        ly = local_y;
        if (dx > lx)      return PORT_E;
        else if (dx < lx) return PORT_W;
        else if (dy > ly) return PORT_N;
        else if (dy < ly) return PORT_S;
        else              return PORT_L;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - one output port: round-robin pick, packet lock, optional lock timeout
module rr_lock_arbiter
    import router_pkg::*;
#(
    parameter int N_IN    = 5,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 0,
    parameter int SEL_W   = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          i_cand,
    input  logic [N_IN*ADDR_W-1:0]   i_src,
    input  logic [N_IN-1:0]          i_tail,
    output logic                     o_valid,
    output logic [SEL_W-1:0]         o_sel,
    output logic [ADDR_W-1:0]        o_src,
    output logic                     o_timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [ADDR_W-1:0]  r_src;
    logic [ADDR_W-1:0]  w_src_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_terr;
    logic               w_terr_nxt;

    logic               w_found;
    logic [SEL_W-1:0]   w_win;
    int                 w_idx;
    logic               w_expired;

    // Search starts at the pointer and wraps, so the last winner is served last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < N_IN; k++) begin
            w_idx = (int'(r_ptr) + k) % N_IN;
            if (!w_found && i_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = SEL_W'(w_idx);
            end
        end
    end

    assign w_expired = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_src_nxt   = r_src;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_terr_nxt  = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                w_cnt_nxt = '0;
                if (w_found) begin
                    w_state_nxt = ARB_LOCKED;
                    w_sel_nxt   = w_win;
                    w_src_nxt   = i_src[int'(w_win)*ADDR_W +: ADDR_W];
                    w_ptr_nxt   = SEL_W'((int'(w_win) + 1) % N_IN);
                end
            end
            ARB_LOCKED: begin
                // A tail arriving on the expiry cycle is a clean finish, not an error.
                if (i_tail[r_sel]) begin
                    w_state_nxt = ARB_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_expired) begin
                    w_state_nxt = ARB_IDLE;
                    w_cnt_nxt   = '0;
                    w_terr_nxt  = 1'b1;
                end else if (TIMEOUT > 0) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_sel   <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_src   <= w_src_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    assign o_valid       = (r_state == ARB_LOCKED);
    assign o_sel         = o_valid ? r_sel : '0;
    assign o_src         = o_valid ? r_src : '0;
    assign o_timeout_err = r_terr;

endmodule

// File: rtl/router_port_arbiter.sv
// rtl/router_port_arbiter.sv - XY routing of N_IN packet heads onto five locked output ports
module router_port_arbiter
    import router_pkg::*;
#(
    parameter int N_IN    = 5,
    parameter int ADDR_W  = 10,
    parameter int X_W     = 5,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0,
    parameter int TIMEOUT = 0,
    localparam int SEL_W  = $clog2(N_IN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_IN-1:0]               in_req,
    input  logic [N_IN*ADDR_W-1:0]        in_src,
    input  logic [N_IN*ADDR_W-1:0]        in_dst,
    input  logic [N_IN-1:0]               in_tail,
    output logic [N_IN-1:0]               in_gnt,
    output logic [N_IN*3-1:0]             in_port,
    output logic [NUM_PORTS-1:0]          out_valid,
    output logic [NUM_PORTS*SEL_W-1:0]    out_sel,
    output logic [NUM_PORTS*ADDR_W-1:0]   out_src,
    output logic [NUM_PORTS-1:0]          timeout_err
);

    logic [2:0]                       w_route [N_IN];
    logic [NUM_PORTS-1:0][N_IN-1:0]   w_cand;
    logic [NUM_PORTS-1:0]             w_valid;
    logic [SEL_W-1:0]                 w_sel [NUM_PORTS];
    logic [N_IN-1:0]                  w_gnt;
    logic [N_IN*3-1:0]                w_port;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_route
        assign w_route[gi] = route_port(32'(in_dst[gi*ADDR_W +: ADDR_W]),
                                        ADDR_W, X_W, LOCAL_X, LOCAL_Y);
    end

    // Inputs that already own an output are masked so each input holds one lock.
    for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_cand
            assign w_cand[go][gi] = in_req[gi] && (w_route[gi] == 3'(go)) && !w_gnt[gi];
        end

        rr_lock_arbiter #(
            .N_IN    (N_IN),
            .ADDR_W  (ADDR_W),
            .TIMEOUT (TIMEOUT),
            .SEL_W   (SEL_W)
        ) u_arb (
            .clk           (clk),
            .rst           (rst),
            .i_cand        (w_cand[go]),
            .i_src         (in_src),
            .i_tail        (in_tail),
            .o_valid       (w_valid[go]),
            .o_sel         (w_sel[go]),
            .o_src         (out_src[go*ADDR_W +: ADDR_W]),
            .o_timeout_err (timeout_err[go])
        );

        assign out_sel[go*SEL_W +: SEL_W] = w_sel[go];
    end

    always_comb begin
        w_gnt  = '0;
        w_port = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (w_valid[o] && (w_sel[o] == SEL_W'(i))) begin
                    w_gnt[i]          = 1'b1;
                    w_port[i*3 +: 3] |= 3'(o);
                end
            end
        end
    end

    assign out_valid = w_valid;
    assign in_gnt    = w_gnt;
    assign in_port   = w_port;

endmodule

// File: tb/tb_router_port_arbiter.sv
// tb/tb_router_port_arbiter.sv - directed and randomized checks of router_port_arbiter against a reference model
module tb_router_port_arbiter;

    localparam int N  = 5;
    localparam int AW = 10;
    localparam int XW = 5;
    localparam int LX = 3;
    localparam int LY = 2;
    localparam int TO = 8;
    localparam int SW = 3;
    localparam int P  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_req;
    logic [N*AW-1:0]   in_src;
    logic [N*AW-1:0]   in_dst;
    logic [N-1:0]      in_tail;
    logic [N-1:0]      in_gnt;
    logic [N*3-1:0]    in_port;
    logic [P-1:0]      out_valid;
    logic [P*SW-1:0]   out_sel;
    logic [P*AW-1:0]   out_src;
    logic [P-1:0]      timeout_err;

    router_port_arbiter #(
        .N_IN(N), .ADDR_W(AW), .X_W(XW), .LOCAL_X(LX), .LOCAL_Y(LY), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .in_req(in_req), .in_src(in_src), .in_dst(in_dst),
        .in_tail(in_tail), .in_gnt(in_gnt), .in_port(in_port), .out_valid(out_valid),
        .out_sel(out_sel), .out_src(out_src), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner per output (-1 = free), locked-cycle count, rotating priority.
    int         m_owner [P];
    int         m_cnt   [P];
    int         m_ptr   [P];
    bit         m_terr  [P];
    logic [9:0] m_src   [P];

    function automatic int mk(input int x, input int y);
        return y * 32 + x;
    endfunction

    localparam int D_L = 3 + 2*32;
    localparam int D_E = 5 + 2*32;
    localparam int D_W = 1 + 2*32;
    localparam int D_N = 3 + 7*32;
    localparam int D_S = 3 + 0*32;

    function automatic int route_of(input int dst);
        int dx;
        int dy;
        dx = dst % 32;
        dy = dst / 32;
        if (dx > LX) return 1;
        if (dx < LX) return 2;
        if (dy > LY) return 3;
        if (dy < LY) return 4;
        return 0;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < P; o++) begin
            m_owner[o] = -1;
            m_cnt[o]   = 0;
            m_ptr[o]   = 0;
            m_terr[o]  = 0;
            m_src[o]   = '0;
        end
    endtask

    task automatic model_step();
        bit held [N];
        int dst;
        for (int i = 0; i < N; i++) held[i] = 0;
        for (int o = 0; o < P; o++) if (m_owner[o] >= 0) held[m_owner[o]] = 1;
        for (int o = 0; o < P; o++) begin
            m_terr[o] = 0;
            if (m_owner[o] >= 0) begin
                if (in_tail[m_owner[o]]) begin
                    m_owner[o] = -1;
                end else if (m_cnt[o] == TO - 1) begin
                    m_owner[o] = -1;
                    m_terr[o]  = 1;
                end else begin
                    m_cnt[o]++;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % N;
                    dst = int'(in_dst[i*AW +: AW]);
                    if (m_owner[o] < 0 && in_req[i] && !held[i] && route_of(dst) == o) begin
                        m_owner[o] = i;
                        m_cnt[o]   = 0;
                        m_ptr[o]   = (i + 1) % N;
                        m_src[o]   = in_src[i*AW +: AW];
                    end
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [P-1:0]    ev, et;
        logic [N-1:0]    eg;
        logic [P*SW-1:0] es, as_;
        logic [P*AW-1:0] esr, asr;
        logic [N*3-1:0]  ep, ap;
        ev = '0; et = '0; eg = '0; es = '0; as_ = '0; esr = '0; asr = '0; ep = '0; ap = '0;
        for (int o = 0; o < P; o++) begin
            et[o] = m_terr[o];
            if (m_owner[o] >= 0) begin
                ev[o]               = 1'b1;
                eg[m_owner[o]]      = 1'b1;
                es[o*SW +: SW]      = SW'(m_owner[o]);
                esr[o*AW +: AW]     = m_src[o];
                ep[m_owner[o]*3 +: 3] = 3'(o);
                as_[o*SW +: SW]     = out_sel[o*SW +: SW];
                asr[o*AW +: AW]     = out_src[o*AW +: AW];
            end
        end
        for (int i = 0; i < N; i++) if (eg[i]) ap[i*3 +: 3] = in_port[i*3 +: 3];
        check_eq("m_valid", 64'(out_valid), 64'(ev));
        check_eq("m_gnt", 64'(in_gnt), 64'(eg));
        check_eq("m_terr", 64'(timeout_err), 64'(et));
        check_eq("m_sel", 64'(as_), 64'(es));
        check_eq("m_src", 64'(asr), 64'(esr));
        check_eq("m_port", 64'(ap), 64'(ep));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        #1;
        compare_model();
        in_tail = '0;
    endtask

    task automatic set_in(input int i, input bit req, input int dst, input int src);
        in_req[i]          = req;
        in_dst[i*AW +: AW] = AW'(dst);
        in_src[i*AW +: AW] = AW'(src);
    endtask

    task automatic rand_cycle();
        int dst;
        for (int i = 0; i < N; i++) begin
            in_req[i] = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 5))
                    0: dst = D_L;
                    1: dst = D_E;
                    2: dst = D_W;
                    3: dst = D_N;
                    4: dst = D_S;
                    default: dst = int'($urandom_range(0, 1023));
                endcase
                in_dst[i*AW +: AW] = AW'(dst);
                in_src[i*AW +: AW] = AW'($urandom_range(0, 1023));
            end
            in_tail[i] = ($urandom_range(0, 3) == 0);
        end
        cycle();
    endtask

    int order [4];
    int exp_order [4] = '{1, 2, 3, 1};
    int len;
    int own;

    initial begin
        rst = 1'b1; in_req = '0; in_src = '0; in_dst = '0; in_tail = '0;
        model_reset();
        repeat (2) cycle();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_gnt", 64'(in_gnt), 64'd0);
        check_eq("rst_src", 64'(out_src), 64'd0);
        rst = 1'b0;
        cycle();

        // single request, eastbound
        set_in(0, 1, mk(5, 0), 'h001);
        cycle();
        check_eq("single_gnt", 64'(in_gnt), 64'h01);
        check_eq("single_valid", 64'(out_valid), 64'h02);
        check_eq("single_sel", 64'(out_sel[SW +: SW]), 64'd0);
        check_eq("single_src", 64'(out_src[AW +: AW]), 64'h001);
        check_eq("single_port", 64'(in_port[2:0]), 64'd1);
        in_req[0] = 1'b0;
        cycle();
        in_tail[0] = 1'b1;
        cycle();
        check_eq("single_release", 64'(out_valid), 64'd0);
        cycle();

        // contention on E
        for (int i = 1; i <= 3; i++) set_in(i, 1, D_E, 'h100 + i);
        for (int g = 0; g < 4; g++) begin
            for (int n = 0; n < 10 && !out_valid[1]; n++) cycle();
            check_eq("cont_grant", 64'(out_valid[1]), 64'd1);
            own = int'(out_sel[SW +: SW]);
            order[g] = own;
            cycle();
            cycle();
            if (g == 3) in_req = '0;
            in_tail[own % N] = 1'b1;
            cycle();
            check_eq("cont_dead", 64'(out_valid[1]), 64'd0);
        end
        for (int g = 0; g < 4; g++) check_eq("cont_order", 64'(order[g]), 64'(exp_order[g]));
        cycle();

        // parallel grants to distinct outputs
        set_in(0, 1, D_E, 'h010);
        set_in(1, 1, D_N, 'h011);
        set_in(2, 1, D_L, 'h012);
        cycle();
        check_eq("par_gnt", 64'(in_gnt), 64'h07);
        check_eq("par_valid", 64'(out_valid), 64'h0b);
        in_req = '0;
        in_tail = 5'b00111;
        cycle();
        check_eq("par_release", 64'(out_valid), 64'd0);

        // timeout on W
        set_in(4, 1, D_W, 'h3aa);
        cycle();
        in_req[4] = 1'b0;
        len = out_valid[2] ? 1 : 0;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (!out_valid[2]) break;
            len++;
        end
        check_eq("to_len", 64'(len), 64'd8);
        check_eq("to_err", 64'(timeout_err[2]), 64'd1);
        cycle();
        check_eq("to_err_clr", 64'(timeout_err[2]), 64'd0);

        // tail on the expiry cycle wins over timeout
        set_in(4, 1, D_S, 'h055);
        cycle();
        in_req[4] = 1'b0;
        repeat (7) cycle();
        check_eq("tail8_held", 64'(out_valid[4]), 64'd1);
        in_tail[4] = 1'b1;
        cycle();
        check_eq("tail8_rel", 64'(out_valid[4]), 64'd0);
        check_eq("tail8_noerr", 64'(timeout_err[4]), 64'd0);

        // withdrawal and stray tail
        set_in(0, 1, D_N, 'h020);
        cycle();
        in_req[0] = 1'b0;
        set_in(3, 1, D_N, 'h030);
        cycle();
        in_tail[2] = 1'b1;
        cycle();
        in_req[3] = 1'b0;
        in_tail[3] = 1'b1;
        cycle();
        check_eq("stray_hold", 64'(out_valid), 64'h08);
        in_tail[0] = 1'b1;
        cycle();
        repeat (3) cycle();
        check_eq("wd_gnt", 64'(in_gnt), 64'd0);
        check_eq("wd_valid", 64'(out_valid), 64'd0);

        // reset during a lock
        set_in(2, 1, D_L, 'h0c2);
        cycle();
        in_req = '0;
        cycle();
        #2 rst = 1'b1;
        #1;
        check_eq("rstmid_valid", 64'(out_valid), 64'd0);
        check_eq("rstmid_gnt", 64'(in_gnt), 64'd0);
        check_eq("rstmid_terr", 64'(timeout_err), 64'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        set_in(1, 1, D_L, 'h0a1);
        set_in(3, 1, D_L, 'h0a3);
        cycle();
        check_eq("rstmid_ptr", 64'(out_sel[0 +: SW]), 64'd1);
        in_req = '0;
        in_tail = 5'b01010;
        cycle();
        cycle();

        for (int c = 0; c < 500; c++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
